sma_hyst_detector: RTL and testbench
====================================

// Module: sma_hyst_detector
// PURPOSE
//  Hysteresis threshold detector with debounce, fed by the moving-average filter output stream.
//  Converts the filtered sample stream into a debounced HIGH/LOW level, rise/fall event pulses,
//  a saturating rise-event counter and a sticky interrupt. Pure consumer: no back-pressure to the filter.
// PARAMETERS
//  DATA_INPUT_WIDTH   16  width of filtered sample (matches filter output width)
//  DEBOUNCE_WIDTH     4   width of cfg_debounce and internal debounce counter
//  EVENT_COUNT_WIDTH  8   width of event_count (saturating)
// PORTS
//  clk            in   1                  clock, all logic on posedge
//  rstn           in   1                  asynchronous active-low reset
//  in_data        in   DATA_INPUT_WIDTH   filtered sample (unsigned)
//  in_data_valid  in   1                  in_data qualifier, single-cycle per sample
//  en             in   1                  detector enable
//  cfg_thresh_hi  in   DATA_INPUT_WIDTH   rise threshold (unsigned)
//  cfg_thresh_lo  in   DATA_INPUT_WIDTH   fall threshold (unsigned)
//  cfg_debounce   in   DEBOUNCE_WIDTH     extra consecutive qualifying samples required (0 = one sample)
//  irq_clr        in   1                  clears irq
//  level_high     out  1                  debounced level, 1 = HIGH state
//  rise_pulse     out  1                  1-cycle pulse on LOW->HIGH commit
//  fall_pulse     out  1                  1-cycle pulse on HIGH->LOW commit
//  event_count    out  EVENT_COUNT_WIDTH  number of rise commits, saturates at all-ones
//  irq            out  1                  sticky, set by any rise/fall commit
// BEHAVIOUR
//  Reset (rstn=0, async): state=LOW, debounce cnt=0, level_high=0, rise/fall_pulse=0, event_count=0, irq=0.
//  All outputs registered. Only cycles with in_data_valid=1 advance the FSM; other cycles hold state.
//  Compares: rise-qualifying = in_data > cfg_thresh_hi (strict); fall-qualifying = in_data < cfg_thresh_lo (strict).
//  Config inputs sampled on each valid cycle, no shadowing; lo>hi is legal, detector simply uses both compares.
//  FSM states: LOW, RISE_PEND, HIGH, FALL_PEND. cnt counts qualifying samples already accepted in PEND.
//   LOW:       rise-qual & cfg_debounce==0 -> HIGH (commit); rise-qual else -> RISE_PEND, cnt=1; else stay.
//   RISE_PEND: rise-qual & cnt==cfg_debounce -> HIGH (commit), cnt=0; rise-qual -> cnt+1;
//              non-qual -> LOW, cnt=0 (no pulse).
//   HIGH:      fall-qual & cfg_debounce==0 -> LOW (commit); fall-qual else -> FALL_PEND, cnt=1; else stay.
//   FALL_PEND: fall-qual & cnt==cfg_debounce -> LOW (commit), cnt=0; fall-qual -> cnt+1;
//              non-qual -> HIGH, cnt=0 (no pulse).
//  Commit total: exactly cfg_debounce+1 consecutive qualifying valid samples; invalid cycles between
//   them do not break the run.
//  cfg_debounce lowered mid-PEND below cnt: next qualifying sample commits (use cnt>=cfg_debounce).
//  Latency: level_high / pulses update the cycle after the clock edge sampling the committing sample.
//  level_high=1 in HIGH and FALL_PEND; 0 in LOW and RISE_PEND.
//  rise_pulse=1 for exactly one cycle per LOW/RISE_PEND->HIGH commit; fall_pulse likewise for ->LOW.
//  event_count +1 on each rise commit, holds at 2^EVENT_COUNT_WIDTH-1.
//  irq: set on any commit; cleared by irq_clr; commit and irq_clr in same cycle -> irq=1 (set wins).
//  en=0: next edge forces state=LOW, cnt=0, level_high=0, pulses=0, no fall_pulse emitted;
//   event_count and irq hold; in_data ignored while en=0.
//  Reset asserted mid-operation: all state returns to reset values immediately, no pulses generated.
// TESTING
//  1. hi=100, lo=50, deb=0, en=1; valid samples 90,101 -> level_high=1, rise_pulse one cycle, event_count=1, irq=1.
//  2. deb=2; samples 120,120,40,120,120,120 -> no commit until 6th sample; single rise_pulse; count=1.
//  3. HIGH, deb=1; samples 49, gap of 5 invalid cycles, 49 -> fall_pulse after 2nd 49; sample 50 between aborts.
//  4. Hysteresis: HIGH, samples 60,100,51 -> stays HIGH, no pulses; sample exactly 100 in LOW -> no rise.
//  5. EVENT_COUNT_WIDTH=2: 5 rise/fall cycles -> event_count stops at 3; irq_clr on a commit cycle -> irq stays 1.
//  6. rstn low mid-RISE_PEND, and en=0 while HIGH -> outputs to reset values / LOW, no pulses, count held on en=0.

Source files
------------

// File: rtl/sma_hyst_detector.sv
// Hysteresis threshold detector with debounce on the filtered sample stream.
// Registered outputs, 1-cycle latency from the committing sample; pure consumer with no back-pressure.
module sma_hyst_detector #(
  parameter int DATA_INPUT_WIDTH  = 16,
  parameter int DEBOUNCE_WIDTH    = 4,
  parameter int EVENT_COUNT_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [DATA_INPUT_WIDTH-1:0]  in_data,
  input  logic                         in_data_valid,
  input  logic                         en,
  input  logic [DATA_INPUT_WIDTH-1:0]  cfg_thresh_hi,
  input  logic [DATA_INPUT_WIDTH-1:0]  cfg_thresh_lo,
  input  logic [DEBOUNCE_WIDTH-1:0]    cfg_debounce,
  input  logic                         irq_clr,
  output logic                         level_high,
  output logic                         rise_pulse,
  output logic                         fall_pulse,
  output logic [EVENT_COUNT_WIDTH-1:0] event_count,
  output logic                         irq
);

  // Bit 1 of the state encoding is the debounced level (HIGH and FALL_PEND).
  localparam logic [1:0] ST_LOW       = 2'd0;
  localparam logic [1:0] ST_RISE_PEND = 2'd1;
  localparam logic [1:0] ST_HIGH      = 2'd2;
  localparam logic [1:0] ST_FALL_PEND = 2'd3;

  localparam logic [DEBOUNCE_WIDTH-1:0]    CNT_ONE = {{(DEBOUNCE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [EVENT_COUNT_WIDTH-1:0] EVT_ONE = {{(EVENT_COUNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [DEBOUNCE_WIDTH-1:0] cnt;
  logic [DEBOUNCE_WIDTH-1:0] cnt_nxt;
  logic                      rise_qual;
  logic                      fall_qual;
  logic                      rise_commit;
  logic                      fall_commit;

  assign rise_qual = in_data > cfg_thresh_hi;
  assign fall_qual = in_data < cfg_thresh_lo;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rise_commit = 1'b0;
    fall_commit = 1'b0;
    if (in_data_valid && en) begin
      case (state)
        ST_LOW: begin
          if (rise_qual) begin
            if (cfg_debounce == '0) begin
              state_nxt   = ST_HIGH;
              rise_commit = 1'b1;
            end else begin
              state_nxt = ST_RISE_PEND;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        ST_RISE_PEND: begin
          // >= so that lowering cfg_debounce mid-run commits on the next qualifying sample
          if (rise_qual) begin
            if (cnt >= cfg_debounce) begin
              state_nxt   = ST_HIGH;
              cnt_nxt     = '0;
              rise_commit = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end else begin
            state_nxt = ST_LOW;
            cnt_nxt   = '0;
          end
        end
        ST_HIGH: begin
          if (fall_qual) begin
            if (cfg_debounce == '0) begin
              state_nxt   = ST_LOW;
              fall_commit = 1'b1;
            end else begin
              state_nxt = ST_FALL_PEND;
              cnt_nxt   = CNT_ONE;
            end
          end
        end
        default: begin
          if (fall_qual) begin
            if (cnt >= cfg_debounce) begin
              state_nxt   = ST_LOW;
              cnt_nxt     = '0;
              fall_commit = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_ONE;
            end
          end else begin
            state_nxt = ST_HIGH;
            cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_LOW;
      cnt        <= '0;
      level_high <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else if (!en) begin
      state      <= ST_LOW;
      cnt        <= '0;
      level_high <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level_high <= state_nxt[1];
      rise_pulse <= rise_commit;
      fall_pulse <= fall_commit;
    end
  end

  // Commits are already gated by en, so count and irq naturally hold while disabled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      event_count <= '0;
      irq         <= 1'b0;
    end else begin
      if (rise_commit && (event_count != '1)) begin
        event_count <= event_count + EVT_ONE;
      end
      if (rise_commit || fall_commit) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sma_hyst_detector.sv
// Directed bench for sma_hyst_detector; a second instance with a 2-bit event
// counter shares the stimulus to exercise counter saturation.
module tb_sma_hyst_detector;

  logic        clk;
  logic        rstn;
  logic [15:0] in_data;
  logic        in_data_valid;
  logic        en;
  logic [15:0] cfg_thresh_hi;
  logic [15:0] cfg_thresh_lo;
  logic [3:0]  cfg_debounce;
  logic        irq_clr;

  logic        level_high, rise_pulse, fall_pulse, irq;
  logic [7:0]  event_count;
  logic        level_high2, rise_pulse2, fall_pulse2, irq2;
  logic [1:0]  event_count2;

  int passed = 0;
  int total  = 0;

  sma_hyst_detector u_dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_data       (in_data),
    .in_data_valid (in_data_valid),
    .en            (en),
    .cfg_thresh_hi (cfg_thresh_hi),
    .cfg_thresh_lo (cfg_thresh_lo),
    .cfg_debounce  (cfg_debounce),
    .irq_clr       (irq_clr),
    .level_high    (level_high),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .event_count   (event_count),
    .irq           (irq)
  );

  sma_hyst_detector #(.EVENT_COUNT_WIDTH(2)) u_dut_sat (
    .clk           (clk),
    .rstn          (rstn),
    .in_data       (in_data),
    .in_data_valid (in_data_valid),
    .en            (en),
    .cfg_thresh_hi (cfg_thresh_hi),
    .cfg_thresh_lo (cfg_thresh_lo),
    .cfg_debounce  (cfg_debounce),
    .irq_clr       (irq_clr),
    .level_high    (level_high2),
    .rise_pulse    (rise_pulse2),
    .fall_pulse    (fall_pulse2),
    .event_count   (event_count2),
    .irq           (irq2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Present one valid sample for one clock; returns at the following negedge.
  task automatic send(input logic [15:0] d);
    in_data       = d;
    in_data_valid = 1'b1;
    @(negedge clk);
    in_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic lvl, input logic rp, input logic fp);
    check({tag, ".level"}, 32'(level_high), 32'(lvl));
    check({tag, ".rise"},  32'(rise_pulse), 32'(rp));
    check({tag, ".fall"},  32'(fall_pulse), 32'(fp));
  endtask

  initial begin
    rstn = 1'b0; in_data = '0; in_data_valid = 1'b0; en = 1'b0;
    cfg_thresh_hi = 16'd100; cfg_thresh_lo = 16'd50; cfg_debounce = 4'd0; irq_clr = 1'b0;
    idle(3);
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    check("rst.count", 32'(event_count), 0);
    check("rst.irq", 32'(irq), 0);
    rstn = 1'b1; en = 1'b1;
    idle(1);

    // Basic rise with no debounce
    send(16'd90);  chk_out("t1.s90", 1'b0, 1'b0, 1'b0);
    send(16'd101); chk_out("t1.s101", 1'b1, 1'b1, 1'b0);
    check("t1.count", 32'(event_count), 1);
    check("t1.irq", 32'(irq), 1);
    idle(1);       chk_out("t1.after", 1'b1, 1'b0, 1'b0);
    send(16'd40);  chk_out("t1.fall", 1'b0, 1'b0, 1'b1);
    irq_clr = 1'b1; idle(1); irq_clr = 1'b0;
    check("t1.irqclr", 32'(irq), 0);

    // Debounce 2: an interrupted run restarts the count
    cfg_debounce = 4'd2;
    send(16'd120); send(16'd120); send(16'd40);
    send(16'd120); send(16'd120);
    chk_out("t2.s5", 1'b0, 1'b0, 1'b0);
    check("t2.irq", 32'(irq), 0);
    send(16'd120); chk_out("t2.s6", 1'b1, 1'b1, 1'b0);
    check("t2.count", 32'(event_count), 2);

    // Debounce 1: invalid gap does not break the run; a 50 aborts FALL_PEND
    cfg_debounce = 4'd1;
    send(16'd49);  chk_out("t3.pend", 1'b1, 1'b0, 1'b0);
    idle(5);       chk_out("t3.gap", 1'b1, 1'b0, 1'b0);
    send(16'd49);  chk_out("t3.commit", 1'b0, 1'b0, 1'b1);
    cfg_debounce = 4'd0;
    send(16'd101); chk_out("t3.rehigh", 1'b1, 1'b1, 1'b0);
    cfg_debounce = 4'd1;
    send(16'd49);  send(16'd50);
    chk_out("t3.abort", 1'b1, 1'b0, 1'b0);
    send(16'd49);  chk_out("t3.restart", 1'b1, 1'b0, 1'b0);
    send(16'd49);  chk_out("t3.commit2", 1'b0, 1'b0, 1'b1);

    // Hysteresis band and strict compares
    cfg_debounce = 4'd0;
    send(16'd100); chk_out("t4.eq_hi", 1'b0, 1'b0, 1'b0);
    send(16'd101); chk_out("t4.rise", 1'b1, 1'b1, 1'b0);
    send(16'd60);  send(16'd100); send(16'd51);
    chk_out("t4.band", 1'b1, 1'b0, 1'b0);
    send(16'd50);  chk_out("t4.eq_lo", 1'b1, 1'b0, 1'b0);
    check("t4.count", 32'(event_count), 4);
    check("t4.sat", 32'(event_count2), 3);

    // Saturation holds; commit beats irq_clr in the same cycle
    send(16'd40);
    in_data = 16'd101; in_data_valid = 1'b1; irq_clr = 1'b1;
    @(negedge clk);
    in_data_valid = 1'b0;
    check("t5.irq_set_wins", 32'(irq), 1);
    irq_clr = 1'b0;
    check("t5.count", 32'(event_count), 5);
    check("t5.sat", 32'(event_count2), 3);
    irq_clr = 1'b1; idle(1); irq_clr = 1'b0;
    check("t5.irqclr", 32'(irq), 0);

    // Debounce lowered below cnt mid-pend commits on the next qualifying sample
    cfg_debounce = 4'd3;
    send(16'd40); send(16'd40);
    chk_out("t5.pend", 1'b1, 1'b0, 1'b0);
    cfg_debounce = 4'd1;
    send(16'd40); chk_out("t5.lowered", 1'b0, 1'b0, 1'b1);

    // Async reset mid-RISE_PEND
    cfg_debounce = 4'd3;
    send(16'd120);
    rstn = 1'b0;
    #1;
    chk_out("t6.rst", 1'b0, 1'b0, 1'b0);
    check("t6.rst_count", 32'(event_count), 0);
    check("t6.rst_irq", 32'(irq), 0);
    @(negedge clk);
    rstn = 1'b1;
    cfg_debounce = 4'd0;
    send(16'd120); chk_out("t6.rise", 1'b1, 1'b1, 1'b0);
    check("t6.count", 32'(event_count), 1);

    // en=0 while HIGH: forced LOW, no fall pulse, count/irq held, data ignored
    en = 1'b0;
    idle(1);       chk_out("t6.dis", 1'b0, 1'b0, 1'b0);
    send(16'd200); chk_out("t6.dis_data", 1'b0, 1'b0, 1'b0);
    check("t6.dis_count", 32'(event_count), 1);
    check("t6.dis_irq", 32'(irq), 1);
    en = 1'b1;
    send(16'd40);  chk_out("t6.reen", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
